// File: rtl/tile_match_engine_if.sv
// Board-side bundle for the tile-matching core: player inputs, tile symbols
// and everything the hex/LED display drivers consume.
interface tile_match_engine_if #(
    parameter int NUM_TILES = 10,
    parameter int SYM_W     = 4,
    parameter int SCORE_W   = 8
);
    logic                         start;
    logic [NUM_TILES-1:0]         sw;
    logic [NUM_TILES*SYM_W-1:0]   tile_sym;
    logic [1:0]                   mode;
    logic [NUM_TILES-1:0]         matched;
    logic [NUM_TILES-1:0]         led;
    logic [SYM_W-1:0]             sym_a;
    logic                         sym_a_vld;
    logic [SYM_W-1:0]             sym_b;
    logic                         sym_b_vld;
    logic [SCORE_W-1:0]           moves;
    logic                         game_over;

    modport master (
        output start, sw, tile_sym,
        input  mode, matched, led, sym_a, sym_a_vld, sym_b, sym_b_vld, moves, game_over
    );

    modport slave (
        input  start, sw, tile_sym,
        output mode, matched, led, sym_a, sym_a_vld, sym_b, sym_b_vld, moves, game_over
    );
endinterface

// File: rtl/tile_match_engine.sv
// Registered game core for the tile-matching game: mode FSM, two-tile reveal
// FSM, programmable reveal timer, saturating move counter and switch edge detect.
module tile_match_engine #(
    parameter int          NUM_TILES     = 10,
    parameter int          SYM_W         = 4,
    parameter int          SCORE_W       = 8,
    parameter int unsigned REVEAL_CYCLES = 100000000
) (
    input  logic               CLOCK_50,
    input  logic               userquit,
    tile_match_engine_if.slave bus
);
    localparam int IDX_W   = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    localparam int TIMER_W = (REVEAL_CYCLES > 1) ? $clog2(REVEAL_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(REVEAL_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_MENU    = 2'b00,
        MODE_INGAME  = 2'b01,
        MODE_ENDGAME = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        PLAY_IDLE,
        PLAY_ONE,
        PLAY_TWO
    } play_t;

    mode_t                mode_q, mode_d;
    play_t                play_q, play_d;

    logic [NUM_TILES-1:0] sw_q;
    logic [NUM_TILES-1:0] matched_q;
    logic [NUM_TILES-1:0] rise;
    logic [NUM_TILES-1:0] cand;
    logic [NUM_TILES-1:0] revealed;
    logic [NUM_TILES-1:0] pair_bits;
    logic [NUM_TILES-1:0] matched_upd;
    logic [IDX_W-1:0]     idx_a_q, idx_b_q, cand_idx;
    logic [SYM_W-1:0]     sym_a_q, sym_b_q;
    logic [SYM_W-1:0]     sym_arr [NUM_TILES];
    logic [TIMER_W-1:0]   timer_q;
    logic [SCORE_W-1:0]   moves_q;
    logic                 game_over_q;
    logic                 cand_found;
    logic                 resolve;
    logic                 final_match;
    logic                 enter_game;

    always_comb begin
        for (int i = 0; i < NUM_TILES; i++) begin
            sym_arr[i] = bus.tile_sym[i*SYM_W +: SYM_W];
        end
    end

    // Tiles already matched or face-up cannot be picked; TWO ignores all edges.
    always_comb begin
        rise = bus.sw & ~sw_q;
        cand = '0;
        if (mode_q == MODE_INGAME && play_q != PLAY_TWO) begin
            cand = rise & ~matched_q & ~revealed;
        end
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int i = NUM_TILES - 1; i >= 0; i--) begin
            if (cand[i]) begin
                cand_found = 1'b1;
                cand_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        pair_bits          = '0;
        pair_bits[idx_a_q] = 1'b1;
        pair_bits[idx_b_q] = 1'b1;
        resolve     = (mode_q == MODE_INGAME) && (play_q == PLAY_TWO) && (timer_q == TIMER_LAST);
        matched_upd = (sym_a_q == sym_b_q) ? (matched_q | pair_bits) : matched_q;
        final_match = &matched_upd;
        enter_game  = (mode_q == MODE_MENU) && bus.start;
    end

    always_ff @(posedge CLOCK_50) begin
        if (userquit) begin
            mode_q <= MODE_MENU;
            play_q <= PLAY_IDLE;
        end else begin
            mode_q <= mode_d;
            play_q <= play_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        play_d = play_q;
        case (mode_q)
            MODE_MENU:    if (bus.start) mode_d = MODE_INGAME;
            MODE_INGAME:  if (resolve && final_match) mode_d = MODE_ENDGAME;
            MODE_ENDGAME: if (bus.start) mode_d = MODE_MENU;
            default:      mode_d = MODE_MENU;
        endcase
        if (mode_q == MODE_INGAME) begin
            case (play_q)
                PLAY_IDLE: if (cand_found) play_d = PLAY_ONE;
                PLAY_ONE:  if (cand_found) play_d = PLAY_TWO;
                PLAY_TWO:  if (resolve) play_d = PLAY_IDLE;
                default:   play_d = PLAY_IDLE;
            endcase
        end else begin
            play_d = PLAY_IDLE;
        end
    end

    // Datapath: selections, reveal timer, score and the end-of-game pulse.
    always_ff @(posedge CLOCK_50) begin
        if (userquit) begin
            sw_q        <= bus.sw;
            matched_q   <= '0;
            moves_q     <= '0;
            game_over_q <= 1'b0;
            idx_a_q     <= '0;
            idx_b_q     <= '0;
            sym_a_q     <= '0;
            sym_b_q     <= '0;
            timer_q     <= '0;
        end else begin
            sw_q        <= bus.sw;
            game_over_q <= 1'b0;
            if (enter_game) begin
                matched_q <= '0;
                moves_q   <= '0;
            end else if (resolve) begin
                matched_q   <= matched_upd;
                game_over_q <= final_match;
                if (moves_q != {SCORE_W{1'b1}}) begin
                    moves_q <= moves_q + SCORE_W'(1);
                end
            end
            if (cand_found && play_q == PLAY_IDLE) begin
                idx_a_q <= cand_idx;
                sym_a_q <= sym_arr[cand_idx];
            end
            if (cand_found && play_q == PLAY_ONE) begin
                idx_b_q <= cand_idx;
                sym_b_q <= sym_arr[cand_idx];
                timer_q <= '0;
            end
            if (play_q == PLAY_TWO) begin
                timer_q <= timer_q + TIMER_W'(1);
            end
        end
    end

    always_comb begin
        revealed      = '0;
        bus.sym_a_vld = 1'b0;
        bus.sym_b_vld = 1'b0;
        if (play_q == PLAY_ONE || play_q == PLAY_TWO) begin
            revealed[idx_a_q] = 1'b1;
            bus.sym_a_vld     = 1'b1;
        end
        if (play_q == PLAY_TWO) begin
            revealed[idx_b_q] = 1'b1;
            bus.sym_b_vld     = 1'b1;
        end
        bus.mode      = mode_q;
        bus.matched   = matched_q;
        bus.led       = matched_q | revealed;
        bus.sym_a     = sym_a_q;
        bus.sym_b     = sym_b_q;
        bus.moves     = moves_q;
        bus.game_over = game_over_q;
    end
endmodule

// File: doc/tile_match_engine.md
Name: tile_match_engine

Overview:
- Parametrised registered game core for the tile-matching game. Handles NUM_TILES tiles, each with a SYM_W-bit symbol, loaded from a port instead of being hard-coded.
- Owns the mode FSM (menu/ingame/endgame) and the in-game FSM (idle/one tile/two tiles).
- Adds behaviour the previous design lacks: a programmable reveal timer, a saturating move counter, and switch edge detection.
- Sits between the board I/O (SW/KEY) and the hex/LED display drivers.

Parameters:
- NUM_TILES, 10, number of tiles, range 2..32.
- SYM_W, 4, symbol width per tile.
- SCORE_W, 8, move counter width.
- REVEAL_CYCLES, 100000000, clock cycles a two-tile reveal is held (2 s at 50 MHz); must be >=1.

Ports:
- CLOCK_50, in, 1: system clock.
- userquit, in, 1: synchronous active-high reset; also serves as the player quit.
- start, in, 1: level signal, begin game from menu.
- sw, in, NUM_TILES: tile select switches, already synchronised.
- tile_sym, in, NUM_TILES*SYM_W: symbol of tile i at [i*SYM_W +: SYM_W]; must be stable during a game.
- mode, out, 2: 00 menu, 01 ingame, 10 endgame.
- matched, out, NUM_TILES: tiles permanently matched.
- led, out, NUM_TILES: matched OR currently revealed tiles.
- sym_a, out, SYM_W: symbol of first revealed tile.
- sym_a_vld, out, 1: sym_a is meaningful.
- sym_b, out, SYM_W: symbol of second revealed tile.
- sym_b_vld, out, 1: sym_b is meaningful.
- moves, out, SCORE_W: completed pair attempts.
- game_over, out, 1: one-cycle pulse when the final pair matches.

Behaviour:
- Reset (userquit=1 at a rising edge):
  - mode=00; in-game state=IDLE.
  - matched=0, led=0, sym_a=sym_b=0, both vld=0, moves=0, game_over=0, timer=0.
  - sw_q<=sw, so switches already high cause no selection after reset.
- Edge detect:
  - rise = sw & ~sw_q, with sw_q updated every cycle.
  - A candidate is a rising bit whose tile is neither matched nor revealed.
  - If several bits rise in one cycle, the lowest index wins; the others are discarded (they must fall and rise again).
- Mode FSM:
  - MENU -> INGAME when start=1. On entry, matched/moves/revealed are cleared.
  - INGAME -> ENDGAME on the cycle the final match commits.
  - ENDGAME -> MENU when start=1. matched and moves are held in ENDGAME for display.
- In-game FSM (active only in INGAME):
  - IDLE: on a candidate at index i, record idx_a=i, sym_a=tile_sym[i], sym_a_vld=1, go to ONE.
  - ONE: on a candidate j, record idx_b=j, sym_b, sym_b_vld=1, timer=0, go to TWO.
  - TWO: timer increments each cycle and all switch edges are ignored. On the cycle timer==REVEAL_CYCLES-1 (resolve cycle):
    - moves increments, saturating at all-ones.
    - If sym_a==sym_b, matched |= bit idx_a | bit idx_b.
    - Clear both vld and the revealed bits; return to IDLE.
    - If the updated matched is all ones, pulse game_over and change mode to ENDGAME in the same edge.
- Reveal latency:
  - The first tile is visible on led the cycle after the edge is seen (sw high + 1 clock).
  - The pair is visible for exactly REVEAL_CYCLES cycles, counting from the cycle after the second selection is registered.
- led = matched | revealed, where revealed holds bits idx_a (from ONE) and idx_b (in TWO). Registered, no combinational path from sw.
- sym_a/sym_b keep their last values when vld=0; consumers must gate on vld.
- The symbol compare is full SYM_W width. A tile pair whose symbols occur an odd number of times can never match; this is a legal configuration, and the game then never ends.
- start high while in INGAME has no effect.
- userquit mid-TWO aborts immediately: no move is counted and nothing is matched.

Test Plan:
- Basic match: NUM_TILES=4, REVEAL_CYCLES=4, tile_sym={1,2,2,1} (tile0=1). Reset, start, raise sw[0] then sw[3] -> led=1001 during TWO for 4 cycles; then matched=1001, moves=1, vld both 0.
- Mismatch: same config, raise sw[0] then sw[1] -> led=0011 for 4 cycles, then led=0000, matched=0000, moves=1.
- Simultaneous and ignored edges:
  - sw 0000->0110 in one cycle -> only tile1 is revealed (sym_a=2).
  - Edges during TWO, and re-raising an already matched tile, leave led/sym unchanged.
- Game end: match {0,3} then {1,2} -> game_over high exactly one cycle, mode=10, moves=2, matched=1111. start -> mode=00. start again -> matched=0, moves=0.
- Saturation: SCORE_W=2, run 5 mismatched attempts -> moves reads 1,2,3,3,3.
- Reset mid-operation: assert userquit in the 2nd cycle of TWO -> next cycle mode=00, led=0, moves=0, game_over never pulses. Hold sw[0]=1 through the reset -> no selection afterwards until sw[0] falls and rises again.
